// File: rtl/general_pkg.sv
// Shared constants and helpers for the buffering primitives.
// Byte-merge works on a wide fixed container; callers cast to and from their own width.
package general_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;
    localparam int MERGE_W         = 1024;

    // Take new_w bytes where be is set, old_w bytes elsewhere.
    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0]   old_w,
        input logic [MERGE_W-1:0]   new_w,
        input logic [MERGE_W/8-1:0] be
    );
        logic [MERGE_W-1:0] m;
        m = old_w;
        for (int i = 0; i < MERGE_W/8; i++) begin
            if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/sdp_ram_pipe.sv
// Read output pipeline: resettable valid shift chain, data stages load only behind a valid bit.
// Latency DEPTH cycles (DEPTH=0 is a wire); no backpressure, one result per cycle.
module sdp_ram_pipe #(
    parameter int WIDTH = 72,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_dat
);

    if (DEPTH == 0) begin : g_pass
        assign out_vld = in_vld;
        assign out_dat = in_dat;
    end else begin : g_regs
        logic [DEPTH-1:0] vld_q;
        logic [WIDTH-1:0] dat_q [DEPTH];

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= '0;
                for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
            end else begin
                vld_q[0] <= in_vld;
                if (in_vld) dat_q[0] <= in_dat;
                for (int i = 1; i < DEPTH; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
                end
            end
        end

        assign out_vld = vld_q[DEPTH-1];
        assign out_dat = dat_q[DEPTH-1];
    end

endmodule

// File: rtl/sdp_ram_be.sv
// Simple-dual-port RAM with byte enables and selectable read-during-write behaviour.
// Read latency LATENCY cycles, 1 read/cycle; no backpressure, rd_dout holds between results.
module sdp_ram_be
    import general_pkg::*;
#(
    parameter int D_WIDTH  = 72,
    parameter int A_WIDTH  = 10,
    parameter int LATENCY  = 2,
    parameter int RDW_MODE = 0,
    parameter int BE_WIDTH = D_WIDTH/8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [BE_WIDTH-1:0] wr_be,
    input  logic [A_WIDTH-1:0]  wr_addr,
    input  logic [D_WIDTH-1:0]  wr_din,
    input  logic                rd_en,
    input  logic [A_WIDTH-1:0]  rd_addr,
    output logic [D_WIDTH-1:0]  rd_dout,
    output logic                rd_valid
);

    localparam int DEPTH = 2**A_WIDTH;

    if (D_WIDTH % 8 != 0) begin : g_bad_width
        $error("sdp_ram_be: D_WIDTH must be a multiple of 8");
    end
    if (BE_WIDTH != D_WIDTH/8) begin : g_bad_be
        $error("sdp_ram_be: BE_WIDTH is derived and must not be overridden");
    end
    if (LATENCY < 1) begin : g_bad_lat
        $error("sdp_ram_be: LATENCY must be >= 1");
    end
    if (D_WIDTH > MERGE_W) begin : g_too_wide
        $error("sdp_ram_be: D_WIDTH exceeds byte_merge container");
    end

    logic [D_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    logic               s1_vld;
    logic [D_WIDTH-1:0] s1_dat;
    logic [D_WIDTH-1:0] rd_word;
    logic [D_WIDTH-1:0] fwd_word;
    logic               collide;

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_din[8*b +: 8];
            end
        end
    end

    // Write-first view of the word being read: incoming bytes over the stored ones.
    always_comb begin
        rd_word  = mem[rd_addr];
        collide  = wr_en && (wr_addr == rd_addr);
        fwd_word = rd_word;
        if (RDW_MODE == RDW_WRITE_FIRST && collide) begin
            fwd_word = D_WIDTH'(byte_merge(MERGE_W'(rd_word), MERGE_W'(wr_din),
                                           (MERGE_W/8)'(wr_be)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
        end else begin
            s1_vld <= rd_en;
            if (rd_en) s1_dat <= fwd_word;
        end
    end

    sdp_ram_pipe #(
        .WIDTH (D_WIDTH),
        .DEPTH (LATENCY-1)
    ) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (s1_vld),
        .in_dat  (s1_dat),
        .out_vld (rd_valid),
        .out_dat (rd_dout)
    );

endmodule

// File: tb/tb_sdp_ram_be.sv
// Three RAM configurations share one stimulus stream and are checked against a
// per-configuration model of timed read results over a plain memory array.
module tb_sdp_ram_be;

    localparam int DW = 72;
    localparam int AW = 10;
    localparam int NI = 3;
    localparam int LAT_TAB [NI] = '{2, 4, 1};
    localparam int RDW_TAB [NI] = '{0, 1, 0};

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_en;
    logic [DW/8-1:0] wr_be;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_din;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;

    logic [NI-1:0]         dut_vld;
    logic [NI-1:0][DW-1:0] dut_dout;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sdp_ram_be #(
            .D_WIDTH  (DW),
            .A_WIDTH  (AW),
            .LATENCY  (LAT_TAB[g]),
            .RDW_MODE (RDW_TAB[g])
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (wr_en),
            .wr_be    (wr_be),
            .wr_addr  (wr_addr),
            .wr_din   (wr_din),
            .rd_en    (rd_en),
            .rd_addr  (rd_addr),
            .rd_dout  (dut_dout[g]),
            .rd_valid (dut_vld[g])
        );
    end

    typedef struct {
        int          due;
        logic [DW-1:0] dat;
    } rsp_t;

    logic [DW-1:0] mem_m [2**AW];
    rsp_t          pend [NI][$];
    logic          exp_vld [NI];
    logic [DW-1:0] exp_dout [NI];
    logic [DW-1:0] got [NI][$];
    int            cyc;
    int            checks;
    int            errors;

    // Advance one clock edge and update the model with what that edge does.
    task automatic tick();
        logic [DW-1:0] old_w;
        logic [DW-1:0] new_w;
        rsp_t          r;
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < NI; k++) begin
                pend[k].delete();
                exp_vld[k]  = 1'b0;
                exp_dout[k] = '0;
            end
        end else begin
            if (rd_en) begin
                old_w = mem_m[rd_addr];
                new_w = old_w;
                if (wr_en && wr_addr == rd_addr)
                    for (int b = 0; b < DW/8; b++)
                        if (wr_be[b]) new_w[8*b +: 8] = wr_din[8*b +: 8];
                for (int k = 0; k < NI; k++) begin
                    r.due = cyc + LAT_TAB[k] - 1;
                    r.dat = (RDW_TAB[k] == 1) ? new_w : old_w;
                    pend[k].push_back(r);
                end
            end
            if (wr_en)
                for (int b = 0; b < DW/8; b++)
                    if (wr_be[b]) mem_m[wr_addr][8*b +: 8] = wr_din[8*b +: 8];
            for (int k = 0; k < NI; k++) begin
                exp_vld[k] = 1'b0;
                if (pend[k].size() > 0 && pend[k][0].due == cyc) begin
                    exp_vld[k]  = 1'b1;
                    exp_dout[k] = pend[k][0].dat;
                    void'(pend[k].pop_front());
                end
            end
        end
        cyc++;
        #1;
        for (int k = 0; k < NI; k++)
            if (dut_vld[k] === 1'b1) got[k].push_back(dut_dout[k]);
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_be = '0; wr_addr = '0; wr_din = '0;
        rd_en = 1'b0; rd_addr = '0;
    endtask

    task automatic clear_got();
        for (int k = 0; k < NI; k++) got[k].delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) begin
            tick();
            checks++;
            if (dut_vld !== '0 || dut_dout !== '0) begin
                errors++;
                $display("FAIL reset_state cyc %0d: vld %b dout0 %h, expected vld 000 dout 0", cyc, dut_vld, dut_dout[0]);
            end
        end
        rst = 1'b0;
        rd_en = 1'b1; rd_addr = 10'd5;
        tick();
        rd_en = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            for (int k = 0; k < NI; k++) begin
                checks++;
                if (dut_vld[k] !== exp_vld[k] || dut_dout[k] !== exp_dout[k]) begin
                    errors++;
                    $display("FAIL reset_read inst%0d cyc %0d: vld %b dout %h, expected vld %b dout %h", k, cyc, dut_vld[k], dut_dout[k], exp_vld[k], exp_dout[k]);
                end
            end
            if (i == 1) begin
                checks++;
                if (dut_vld[0] !== 1'b1 || dut_dout[0] !== '0) begin
                    errors++;
                    $display("FAIL reset_read_lat2: vld %b dout %h, expected vld 1 dout 0", dut_vld[0], dut_dout[0]);
                end
            end
        end
    endtask

    task automatic test_byte_enable();
        clear_got();
        wr_en = 1'b1; wr_be = '1; wr_addr = 10'd3; wr_din = 72'h01020304050607AABB;
        tick();
        wr_be = 9'h001; wr_din = 72'hFFFFFFFFFFFFFF1122;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1; rd_addr = 10'd3;
        tick();
        rd_en = 1'b0;
        repeat (4) begin
            tick();
            for (int k = 0; k < NI; k++) begin
                checks++;
                if (dut_vld[k] !== exp_vld[k] || dut_dout[k] !== exp_dout[k]) begin
                    errors++;
                    $display("FAIL byte_enable inst%0d cyc %0d: vld %b dout %h, expected vld %b dout %h", k, cyc, dut_vld[k], dut_dout[k], exp_vld[k], exp_dout[k]);
                end
            end
        end
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (got[k].size() != 1 || got[k][0] !== 72'h01020304050607AA22) begin
                errors++;
                $display("FAIL byte_enable_word inst%0d: %0d results first %h, expected 1 result 01020304050607aa22", k, got[k].size(), (got[k].size() > 0) ? got[k][0] : 72'h0);
            end
        end
    endtask

    task automatic test_collision();
        logic [DW-1:0] first_exp;
        clear_got();
        wr_en = 1'b1; wr_be = '1; wr_addr = 10'd7; wr_din = 72'h10;
        tick();
        wr_din = 72'h20; rd_en = 1'b1; rd_addr = 10'd7;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        repeat (4) tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        repeat (4) begin
            tick();
            for (int k = 0; k < NI; k++) begin
                checks++;
                if (dut_vld[k] !== exp_vld[k] || dut_dout[k] !== exp_dout[k]) begin
                    errors++;
                    $display("FAIL collision inst%0d cyc %0d: vld %b dout %h, expected vld %b dout %h", k, cyc, dut_vld[k], dut_dout[k], exp_vld[k], exp_dout[k]);
                end
            end
        end
        for (int k = 0; k < NI; k++) begin
            first_exp = (RDW_TAB[k] == 1) ? 72'h20 : 72'h10;
            checks++;
            if (got[k].size() != 2 || got[k][0] !== first_exp || got[k][1] !== 72'h20) begin
                errors++;
                $display("FAIL collision_words inst%0d: %0d results, first %h, expected 2 results %h then 20", k, got[k].size(), (got[k].size() > 0) ? got[k][0] : 72'h0, first_exp);
            end
        end
    endtask

    task automatic test_streaming();
        clear_got();
        wr_en = 1'b1; wr_be = '1;
        for (int a = 0; a < 16; a++) begin
            wr_addr = AW'(a); wr_din = DW'(a);
            tick();
        end
        wr_en = 1'b0;
        for (int a = 0; a < 22; a++) begin
            rd_en = (a < 16);
            rd_addr = AW'(a % 16);
            tick();
            for (int k = 0; k < NI; k++) begin
                checks++;
                if (dut_vld[k] !== exp_vld[k] || dut_dout[k] !== exp_dout[k]) begin
                    errors++;
                    $display("FAIL streaming inst%0d cyc %0d: vld %b dout %h, expected vld %b dout %h", k, cyc, dut_vld[k], dut_dout[k], exp_vld[k], exp_dout[k]);
                end
            end
        end
        rd_en = 1'b0;
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (got[k].size() != 16) begin
                errors++;
                $display("FAIL streaming_count inst%0d: %0d results, expected 16", k, got[k].size());
            end else begin
                for (int i = 0; i < 16; i++) begin
                    checks++;
                    if (got[k][i] !== DW'(i)) begin
                        errors++;
                        $display("FAIL streaming_order inst%0d idx %0d: %h, expected %h", k, i, got[k][i], DW'(i));
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        clear_got();
        for (int i = 0; i < 3; i++) begin
            rd_en = 1'b1; rd_addr = AW'(i);
            rst = (i == 2);
            tick();
        end
        rst = 1'b0; rd_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            for (int k = 0; k < NI; k++) begin
                checks++;
                if (dut_vld[k] !== exp_vld[k] || dut_dout[k] !== exp_dout[k]) begin
                    errors++;
                    $display("FAIL reset_midflight inst%0d cyc %0d: vld %b dout %h, expected vld %b dout %h", k, cyc, dut_vld[k], dut_dout[k], exp_vld[k], exp_dout[k]);
                end
            end
        end
        checks++;
        if (got[1].size() != 0) begin
            errors++;
            $display("FAIL reset_midflight_lat4: %0d valid pulses, expected 0", got[1].size());
        end
        clear_got();
        rd_en = 1'b1; rd_addr = 10'd2;
        tick();
        rd_en = 1'b0;
        repeat (5) tick();
        checks++;
        if (got[1].size() != 1 || got[1][0] !== 72'h2) begin
            errors++;
            $display("FAIL reset_midflight_array: %0d results first %h, expected 1 result 2", got[1].size(), (got[1].size() > 0) ? got[1][0] : 72'h0);
        end
    endtask

    task automatic test_wrap_hold();
        clear_got();
        wr_en = 1'b1; wr_be = '1; wr_addr = '1; wr_din = '1;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1; rd_addr = '1;
        tick();
        rd_en = 1'b0;
        repeat (5) begin
            tick();
            for (int k = 0; k < NI; k++) begin
                checks++;
                if (dut_vld[k] !== exp_vld[k] || dut_dout[k] !== exp_dout[k]) begin
                    errors++;
                    $display("FAIL wrap_hold inst%0d cyc %0d: vld %b dout %h, expected vld %b dout %h", k, cyc, dut_vld[k], dut_dout[k], exp_vld[k], exp_dout[k]);
                end
            end
        end
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (got[k].size() != 1 || dut_vld[k] !== 1'b0 || dut_dout[k] !== {DW{1'b1}}) begin
                errors++;
                $display("FAIL wrap_hold_final inst%0d: %0d pulses vld %b dout %h, expected 1 pulse vld 0 dout all ones", k, got[k].size(), dut_vld[k], dut_dout[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            rst     = ($urandom_range(0, 49) == 0);
            wr_en   = $urandom_range(0, 1) == 1;
            wr_be   = DW/8'($urandom);
            wr_addr = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            wr_din  = {$urandom, $urandom, $urandom};
            rd_en   = $urandom_range(0, 2) != 0;
            rd_addr = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            tick();
            for (int k = 0; k < NI; k++) begin
                checks++;
                if (dut_vld[k] !== exp_vld[k] || dut_dout[k] !== exp_dout[k]) begin
                    errors++;
                    $display("FAIL random inst%0d cyc %0d: vld %b dout %h, expected vld %b dout %h", k, cyc, dut_vld[k], dut_dout[k], exp_vld[k], exp_dout[k]);
                end
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        for (int a = 0; a < 2**AW; a++) mem_m[a] = '0;
        for (int k = 0; k < NI; k++) begin
            exp_vld[k]  = 1'b0;
            exp_dout[k] = '0;
        end
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_byte_enable();
        test_collision();
        test_streaming();
        test_reset_midflight();
        test_wrap_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdp_ram_be.md
Name: sdp_ram_be

Overview:
Parametrised simple-dual-port block RAM with one write port and one read port on a single clock. Adds per-byte write enables, read enable, selectable read-during-write collision mode, configurable read latency, and a resettable read-valid pipeline. Used as the general buffering primitive in the correlator and beamformer datapaths, for example accumulator banks and reorder buffers, where writes and reads to different addresses proceed in the same cycle.

Parameters:
D_WIDTH, 72, data width in bits; must be a multiple of 8 (elaboration error otherwise).
A_WIDTH, 10, address width; depth = 2**A_WIDTH words.
LATENCY, 2, read latency in cycles, from rd_en sampled to rd_valid/rd_dout; must be >= 1.
RDW_MODE, 0, same-address read-during-write result: 0 = old data (read-first), 1 = new data (write-first, byte-merged).
BE_WIDTH, D_WIDTH/8, byte-enable width; derived, do not override.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
wr_en  in  1  write strobe.
wr_be  in  BE_WIDTH  byte enables; bit i covers din bits [8i+7:8i].
wr_addr  in  A_WIDTH  write address.
wr_din  in  D_WIDTH  write data.
rd_en  in  1  read strobe.
rd_addr  in  A_WIDTH  read address.
rd_dout  out  D_WIDTH  read data.
rd_valid  out  1  rd_dout carries the result of a read issued LATENCY cycles earlier.

Behaviour:
- Memory array is initialised to all zeros at time zero. rst does not clear the array.
- Reset values: rd_valid = 0 and rd_dout = 0. Every stage of the valid and data pipeline is cleared to 0.
- Write: on a clk edge with wr_en=1 and rst=0, mem[wr_addr] byte i <= wr_din byte i for each wr_be[i]=1. Other bytes are unchanged. wr_en=1 with wr_be=0 is a no-op.
- Read: on a clk edge with rd_en=1 and rst=0, the word at rd_addr is captured in stage 1. It then passes through LATENCY-1 further register stages.
  - rd_valid is asserted exactly LATENCY cycles after the rd_en edge and lasts one cycle per read.
  - Back-to-back reads give one result per cycle, so throughput is 1 read/cycle.
- rd_en=0: a 0 enters the valid pipe. rd_dout holds the last valid data; the data pipe stages load only when their valid bit is 1.
- Collision (rd_en & wr_en, rd_addr == wr_addr, same edge):
  - RDW_MODE=0: read returns the pre-write word.
  - RDW_MODE=1: read returns wr_din bytes where wr_be=1, and the old bytes elsewhere.
  - In both modes the array holds the merged word after the edge.
- Different-address simultaneous read and write: fully independent.
- rst=1 mid-operation:
  - wr_en and rd_en are ignored on that edge.
  - All in-flight reads are discarded; rd_valid is 0 from the edge where rst is sampled high.
  - The first read after rst deasserts behaves normally, with full LATENCY.
- Address wrap: addresses are A_WIDTH bits, so there is no out-of-range case.
- No X propagation from unwritten locations, because of the zero initialisation.

Decomposition:
- Shared package general_pkg:
  - RDW_READ_FIRST = 0 and RDW_WRITE_FIRST = 1 constants.
  - A byte-merge function (old, new, be) -> merged word, reused by the collision path.
- Sub-module sdp_ram_pipe(WIDTH, DEPTH):
  - Resettable valid shift register plus a data register chain gated by the valid bits.
  - Instantiated once with DEPTH = LATENCY-1.
  - Keeps the array logic inferable as BRAM, with the output pipeline mapping to BRAM output registers.

Test Plan:
1. Reset then read: rst 2 cycles, read addr 5 (LATENCY=2) -> rd_valid=1 on the 2nd cycle after rd_en, rd_dout=0; rd_valid=0 during rst.
2. Byte-enable write: write 0x..AABB at addr 3 with all wr_be bits set, then write 0x..1122 with wr_be=0x01, read addr 3 -> low byte 0x22, byte 1 0xAA, upper bytes from the first write.
3. Collision: mem[7]=0x10, same edge write 0x20 (all bytes) and read 7 -> RDW_MODE=0 returns 0x10, RDW_MODE=1 returns 0x20; a subsequent read returns 0x20 in both modes.
4. Streaming: write addrs 0..15 with data = addr, then rd_en for 16 consecutive cycles on addrs 0..15 -> rd_valid high 16 consecutive cycles, rd_dout = 0..15 in order, at LATENCY=1 and LATENCY=4.
5. Reset mid-flight: LATENCY=4, issue reads at cycles 0..2, assert rst at cycle 2 -> no rd_valid pulse at all; the read at cycle 2 is ignored; the array is unchanged (verify by a later read).
6. Hold and wrap: read max address (2**A_WIDTH-1) after writing 0xFF bytes there, then rd_en=0 for 5 cycles -> rd_valid 1 for one cycle, rd_dout holds the value with rd_valid=0.
